// File: rtl/wb_spi_master.sv
// wb_spi_master: Wishbone classic SPI master (DATA/CTRL/CS/STATUS regs, CPOL/CPHA, bit order, SCK divider, NUM_CS active-low selects, level irq)
module wb_spi_master #(
  parameter int NUM_CS      = 1,
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 11
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [3:0]        wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic              wb_ack_o,
  output logic              spi_sck_o,
  output logic              spi_mosi_o,
  input  logic              spi_miso_i,
  output logic [NUM_CS-1:0] spi_cs_n_o,
  output logic              irq_o
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0]           r_state;
  logic                 r_ack, r_sck, r_mosi, r_in;
  logic [31:0]          r_dat_o;
  logic                 r_cpha, r_cpol, r_lsb, r_irq_en;
  logic [DIV_WIDTH-1:0] r_div, r_cnt;
  logic [NUM_CS-1:0]    r_cs_en;
  logic                 r_rx_valid, r_overrun;
  logic [7:0]           r_rx, r_sh, w_shift;
  logic [4:0]           r_edge, w_edge;
  logic                 w_req, w_in, w_tx, w_next, w_data_wr, w_unused;
  logic [31:0]          w_ctrl, w_rdata;
  always_comb begin
    w_req     = wb_cyc_i & wb_stb_i & ~r_ack;
    w_data_wr = w_req & wb_we_i & (wb_adr_i[3:2] == 2'd0) & wb_sel_i[0];
    w_edge    = r_edge + 5'd1;
    w_in      = r_cpha ? spi_miso_i : r_in;
    w_tx      = r_lsb ? r_sh[0] : r_sh[7];
    w_shift   = r_lsb ? {w_in, r_sh[7:1]} : {r_sh[6:0], w_in};
    w_next    = r_lsb ? w_shift[0] : w_shift[7];
    w_ctrl    = (32'(r_div) << 8) | {28'd0, r_irq_en, r_lsb, r_cpol, r_cpha};
    w_rdata   = wb_adr_i[3:2] == 2'd0 ? {24'd0, r_rx} :
                wb_adr_i[3:2] == 2'd1 ? w_ctrl :
                wb_adr_i[3:2] == 2'd2 ? 32'(r_cs_en) :
                {29'd0, r_overrun, r_rx_valid, r_state == SHIFT};
    w_unused  = &{wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i};
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state    <= IDLE;
      r_ack      <= 1'b0;
      r_dat_o    <= '0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_in       <= 1'b0;
      {r_irq_en, r_lsb, r_cpol, r_cpha} <= '0;
      r_div      <= DIV_WIDTH'(DEFAULT_DIV);
      r_cnt      <= '0;
      r_edge     <= '0;
      r_cs_en    <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_rx       <= '0;
      r_sh       <= '0;
    end else begin
      r_ack <= w_req;
      if (w_req) r_dat_o <= w_rdata;
      if (w_req && wb_we_i && wb_adr_i[3:2] == 2'd1 && r_state == IDLE)
        {r_div, r_irq_en, r_lsb, r_cpol, r_cpha} <= {wb_dat_i[8+:DIV_WIDTH], wb_dat_i[3:0]};
      if (w_req && wb_we_i && wb_adr_i[3:2] == 2'd2 && wb_sel_i[0]) r_cs_en <= wb_dat_i[NUM_CS-1:0];
      if (w_req && !wb_we_i && wb_adr_i[3:2] == 2'd0) begin
        r_rx_valid <= 1'b0;
        r_overrun  <= 1'b0;
      end
      if (r_state == IDLE) begin
        r_sck <= r_cpol;
        if (w_data_wr) begin
          r_state <= SHIFT;
          r_sh    <= wb_dat_i[7:0];
          r_cnt   <= '0;
          r_edge  <= '0;
          if (!r_cpha) r_mosi <= r_lsb ? wb_dat_i[0] : wb_dat_i[7];
        end
      end else if (r_cnt != r_div) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt  <= '0;
        r_sck  <= ~r_sck;
        r_edge <= w_edge;
        if (w_edge[0]) begin
          if (r_cpha) r_mosi <= w_tx;
          else r_in <= spi_miso_i;
        end else begin
          r_sh <= w_shift;
          if (!r_cpha) r_mosi <= w_next;
        end
        if (w_edge == 5'd16) begin
          r_state    <= IDLE;
          r_rx       <= w_shift;
          r_rx_valid <= 1'b1;
          r_overrun  <= r_overrun | r_rx_valid;
        end
      end
    end
  end
  assign wb_ack_o   = r_ack;
  assign wb_dat_o   = r_dat_o;
  assign spi_sck_o  = r_sck;
  assign spi_mosi_o = r_mosi;
  assign spi_cs_n_o = ~r_cs_en;
  assign irq_o      = r_rx_valid & r_irq_en;
endmodule
